// File: rtl/lcd_disp_pkg.sv
// Shared types and constants for the LCD display scheduler.
// Covers the FSM states, the DHT11 frame field positions and the BCD widths.
package lcd_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_CONV  = 2'd2
    } state_t;

    localparam int unsigned BCD_W    = 4;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned FRAC_MAX = 99;

    // Bit offsets of each byte in the 40-bit DHT11 frame
    localparam int unsigned HUM_INT_LSB = 32;
    localparam int unsigned HUM_DEC_LSB = 24;
    localparam int unsigned TMP_INT_LSB = 16;
    localparam int unsigned TMP_DEC_LSB = 8;
    localparam int unsigned CSUM_LSB    = 0;

    function automatic logic [BYTE_W-1:0] frac_clamp(input logic [BYTE_W-1:0] v);
        return (v > BYTE_W'(FRAC_MAX)) ? BYTE_W'(FRAC_MAX) : v;
    endfunction

endpackage

// File: rtl/lcd_disp_sched_bin2bcd.sv
// Sequential 8-bit double-dabble: one load cycle, then eight add-3/shift cycles.
// done_c and bcd_c are valid combinationally during the final shift cycle.
module bin2bcd8_seq
    import lcd_disp_pkg::*;
(
    input  logic                 lcd_pclk,
    input  logic                 sys_rst_n,
    input  logic                 start,
    input  logic [BYTE_W-1:0]    bin,
    output logic                 done_c,
    output logic [3*BCD_W-1:0]   bcd_c
);

    localparam int unsigned SH_W  = 3*BCD_W + BYTE_W;
    localparam int unsigned CNT_W = 4;

    logic [SH_W-1:0]  sh_q;
    logic [SH_W-1:0]  adj_c;
    logic [SH_W-1:0]  nxt_c;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
        return (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;
    endfunction

    always_comb begin
        adj_c = {add3(sh_q[SH_W-1 -: BCD_W]),
                 add3(sh_q[SH_W-1-BCD_W -: BCD_W]),
                 add3(sh_q[BYTE_W+BCD_W-1 -: BCD_W]),
                 sh_q[BYTE_W-1:0]};
        nxt_c = SH_W'({adj_c, 1'b0});
    end

    assign done_c = (cnt_q == CNT_W'(1));
    assign bcd_c  = nxt_c[SH_W-1 -: 3*BCD_W];

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (start) begin
            sh_q  <= SH_W'(bin);
            cnt_q <= CNT_W'(BYTE_W);
        end else if (cnt_q != '0) begin
            sh_q  <= nxt_c;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/lcd_disp_sched.sv
// DHT11 frame validator, BCD converter and page scheduler for the LCD display.
// Outputs only change on frame_start so a displayed frame never tears.
module lcd_disp_sched
    import lcd_disp_pkg::*;
#(
    parameter int unsigned PAGE_CYCLES = 66_000_000,
    parameter int unsigned CNT_W       = 27
)(
    input  logic        lcd_pclk,
    input  logic        sys_rst_n,
    input  logic [39:0] dht_data,
    input  logic        dht_valid,
    input  logic        frame_start,
    output logic [19:0] data,
    output logic        sign,
    output logic        flag_mux,
    output logic        busy,
    output logic        csum_err
);

    localparam int unsigned FRAME_W = 40;
    localparam int unsigned INT_W   = 3*BCD_W;
    localparam int unsigned FRAC_W  = 2*BCD_W;
    localparam int unsigned DATA_W  = INT_W + FRAC_W;
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(PAGE_CYCLES - 1);

    state_t              state_q, state_nxt;
    logic [FRAME_W-1:0]  frame_q, pend_q;
    logic                pend_vld_q;
    logic [1:0]          fld_q;
    logic                start_q;
    logic [INT_W-1:0]    hum_int_q, tmp_int_q;
    logic [FRAC_W-1:0]   hum_dec_q;
    logic [DATA_W-1:0]   tmp_sh_q, hum_sh_q;
    logic                tmp_sign_q, shadow_vld_q;
    logic [CNT_W-1:0]    timer_q;
    logic                page_q;

    logic [BYTE_W-1:0]   conv_bin_c, csum_calc_c;
    logic [INT_W-1:0]    conv_bcd_c;
    logic                conv_done_c, csum_ok_c, take_c, last_c;

    bin2bcd8_seq u_bcd (
        .lcd_pclk  (lcd_pclk),
        .sys_rst_n (sys_rst_n),
        .start     (start_q),
        .bin       (conv_bin_c),
        .done_c    (conv_done_c),
        .bcd_c     (conv_bcd_c)
    );

    // Frame checks and converter operand select (fields in display order)
    always_comb begin
        csum_calc_c = frame_q[HUM_INT_LSB +: BYTE_W] + frame_q[HUM_DEC_LSB +: BYTE_W]
                    + frame_q[TMP_INT_LSB +: BYTE_W] + frame_q[TMP_DEC_LSB +: BYTE_W];
        csum_ok_c   = (csum_calc_c == frame_q[CSUM_LSB +: BYTE_W]);
        take_c      = dht_valid | pend_vld_q;
        last_c      = (state_q == ST_CONV) && conv_done_c && (fld_q == 2'd3);
        case (fld_q)
            2'd0:    conv_bin_c = frame_q[HUM_INT_LSB +: BYTE_W];
            2'd1:    conv_bin_c = frac_clamp(frame_q[HUM_DEC_LSB +: BYTE_W]);
            2'd2:    conv_bin_c = frame_q[TMP_INT_LSB +: BYTE_W];
            default: conv_bin_c = frac_clamp({1'b0, frame_q[TMP_DEC_LSB +: BYTE_W-1]});
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (take_c) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = csum_ok_c ? ST_CONV : ST_IDLE;
            ST_CONV:  if (last_c) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_nxt;
    end

    // Frame intake; a frame arriving while busy parks in the pending slot
    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && take_c) begin
            frame_q    <= dht_valid ? dht_data : pend_q;
            pend_vld_q <= 1'b0;
        end else if (dht_valid && (state_q != ST_IDLE)) begin
            pend_q     <= dht_data;
            pend_vld_q <= 1'b1;
        end
    end

    // Checksum verdict, field sequencing and whole-frame shadow update
    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy       <= 1'b0;
            csum_err   <= 1'b0;
            start_q    <= 1'b0;
            fld_q      <= '0;
            hum_int_q  <= '0;
            hum_dec_q  <= '0;
            tmp_int_q  <= '0;
            tmp_sh_q   <= '0;
            hum_sh_q   <= '0;
            tmp_sign_q <= 1'b0;
        end else begin
            busy    <= (state_nxt != ST_IDLE);
            start_q <= 1'b0;
            if (state_q == ST_CHECK) begin
                csum_err <= !csum_ok_c;
                start_q  <= csum_ok_c;
                fld_q    <= '0;
            end
            if ((state_q == ST_CONV) && conv_done_c) begin
                fld_q   <= fld_q + 2'd1;
                start_q <= (fld_q != 2'd3);
                case (fld_q)
                    2'd0:    hum_int_q <= conv_bcd_c;
                    2'd1:    hum_dec_q <= conv_bcd_c[FRAC_W-1:0];
                    2'd2:    tmp_int_q <= conv_bcd_c;
                    default: begin
                        tmp_sh_q   <= {tmp_int_q, conv_bcd_c[FRAC_W-1:0]};
                        tmp_sign_q <= frame_q[TMP_DEC_LSB+BYTE_W-1];
                        hum_sh_q   <= {hum_int_q, hum_dec_q};
                    end
                endcase
            end
        end
    end

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timer_q <= '0;
            page_q  <= 1'b0;
        end else if (timer_q == TIMER_LAST) begin
            timer_q <= '0;
            page_q  <= ~page_q;
        end else begin
            timer_q <= timer_q + CNT_W'(1);
        end
    end

    // Commit at frame start; a shadow landing on the same edge waits for the next one
    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data         <= '0;
            sign         <= 1'b0;
            flag_mux     <= 1'b0;
            shadow_vld_q <= 1'b0;
        end else begin
            if (last_c)           shadow_vld_q <= 1'b1;
            else if (frame_start) shadow_vld_q <= 1'b0;
            if (frame_start) begin
                flag_mux <= page_q;
                if (shadow_vld_q || (page_q != flag_mux)) begin
                    data <= page_q ? hum_sh_q : tmp_sh_q;
                    sign <= page_q ? 1'b0 : tmp_sign_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_disp_sched.sv
// Directed and randomized checks of lcd_disp_sched against a value-level display model.
module tb_lcd_disp_sched;

    localparam int unsigned PAGE = 100;

    logic        lcd_pclk, sys_rst_n, dht_valid, frame_start;
    logic [39:0] dht_data;
    logic [19:0] data;
    logic        sign, flag_mux, busy, csum_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [19:0] m_tmp, m_hum;
    logic        m_sign;
    logic [39:0] f, fb;
    int          nb;
    logic        good;

    lcd_disp_sched #(.PAGE_CYCLES(PAGE), .CNT_W(7)) dut (
        .lcd_pclk    (lcd_pclk),
        .sys_rst_n   (sys_rst_n),
        .dht_data    (dht_data),
        .dht_valid   (dht_valid),
        .frame_start (frame_start),
        .data        (data),
        .sign        (sign),
        .flag_mux    (flag_mux),
        .busy        (busy),
        .csum_err    (csum_err)
    );

    initial lcd_pclk = 1'b0;
    always #5 lcd_pclk = ~lcd_pclk;

    // Cycles since reset release; the page shown is (cyc / PAGE) parity
    always @(posedge lcd_pclk) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] to_disp(input int ip, input int fr);
        int fc;
        fc = (fr > 99) ? 99 : fr;
        return {4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10), 4'(fc / 10), 4'(fc % 10)};
    endfunction

    function automatic logic [39:0] mk_frame(input int hi, input int hd, input int ti,
                                             input int td, input logic ok);
        int s;
        s = (hi + hd + ti + td) % 256;
        if (!ok) s = (s + 1) % 256;
        return {8'(hi), 8'(hd), 8'(ti), 8'(td), 8'(s)};
    endfunction

    function automatic logic csum_good(input logic [39:0] fr);
        return ((int'(fr[39:32]) + int'(fr[31:24]) + int'(fr[23:16]) + int'(fr[15:8])) % 256)
               == int'(fr[7:0]);
    endfunction

    task automatic model_apply(input logic [39:0] fr);
        if (csum_good(fr)) begin
            m_hum  = to_disp(int'(fr[39:32]), int'(fr[31:24]));
            m_tmp  = to_disp(int'(fr[23:16]), int'(fr[14:8]));
            m_sign = fr[15];
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge lcd_pclk);
    endtask

    task automatic send(input logic [39:0] fr);
        dht_data  = fr;
        dht_valid = 1'b1;
        @(negedge lcd_pclk);
        dht_valid = 1'b0;
    endtask

    task automatic commit(input string tag);
        logic p;
        p = ((cyc / PAGE) % 2) == 1;
        frame_start = 1'b1;
        @(negedge lcd_pclk);
        frame_start = 1'b0;
        chk({tag, ".flag"}, 32'(flag_mux), 32'(p));
        chk({tag, ".data"}, 32'(data), 32'(p ? m_hum : m_tmp));
        chk({tag, ".sign"}, 32'(sign), 32'(p ? 1'b0 : m_sign));
    endtask

    task automatic both_pages(input string tag);
        commit({tag, ".a"});
        ticks(PAGE - 1);
        commit({tag, ".b"});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".data"}, 32'(data), 32'h0);
        chk({tag, ".sign"}, 32'(sign), 32'h0);
        chk({tag, ".flag"}, 32'(flag_mux), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".cerr"}, 32'(csum_err), 32'h0);
    endtask

    initial begin
        sys_rst_n = 1'b0; dht_valid = 1'b0; frame_start = 1'b0; dht_data = '0;
        m_tmp = '0; m_hum = '0; m_sign = 1'b0;
        ticks(3);
        check_zero("reset");
        sys_rst_n = 1'b1;

        // No frames yet: display stays at +000.00 on either page
        commit("idle0");
        ticks(7);
        commit("idle1");
        both_pages("idle2");

        f = 40'h37_00_19_05_55;
        send(f);
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy) nb++;
            @(negedge lcd_pclk);
        end
        chk("busy_len", 32'(nb), 32'd37);
        chk("pos.cerr", 32'(csum_err), 32'h0);
        model_apply(f);
        both_pages("pos");

        f = 40'h37_00_19_83_D3;
        send(f);
        ticks(45);
        model_apply(f);
        both_pages("neg");

        f = 40'h37_00_19_05_56;
        send(f);
        chk("bad.cerr_n1", 32'(csum_err), 32'h0);
        ticks(1);
        chk("bad.cerr_n2", 32'(csum_err), 32'h1);
        ticks(40);
        model_apply(f);
        commit("bad_hold");
        f = mk_frame(40, 12, 21, 7, 1'b1);
        send(f);
        ticks(1);
        chk("clr.cerr", 32'(csum_err), 32'h0);
        ticks(40);
        model_apply(f);
        commit("clr");

        for (int k = 0; k < 10; k++) begin
            good = ($urandom_range(0, 3) != 0);
            f = mk_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), good);
            send(f);
            ticks(1);
            chk($sformatf("rnd%0d.cerr", k), 32'(csum_err), 32'(!good));
            ticks(38);
            model_apply(f);
            commit($sformatf("rnd%0d", k));
        end

        // Second frame arrives mid-conversion and is handled after the first
        f  = 40'h37_00_19_05_55;
        fb = 40'h37_00_1A_00_51;
        send(f);
        ticks(4);
        send(fb);
        ticks(90);
        chk("b2b.busy", 32'(busy), 32'h0);
        model_apply(fb);
        both_pages("b2b");

        // frame_start on the last conversion cycle commits the previous shadow
        f = mk_frame(int'($urandom_range(60, 99)), 50, int'($urandom_range(100, 255)), 42, 1'b1);
        send(f);
        ticks(36);
        commit("coll_old");
        model_apply(f);
        commit("coll_new");
        ticks(PAGE - 1);
        commit("coll_other");

        // frame_start on the timer wrap cycle still shows the outgoing page
        for (int i = 0; i < 2 * PAGE && (cyc % PAGE) != PAGE - 1; i++) @(negedge lcd_pclk);
        commit("wrap");
        commit("after_wrap");

        f = mk_frame(77, 3, 30, 9, 1'b1);
        send(f);
        ticks(15);
        #2 sys_rst_n = 1'b0;
        #1 check_zero("rst_mid");
        ticks(3);
        sys_rst_n = 1'b1;
        m_tmp = '0; m_hum = '0; m_sign = 1'b0;
        ticks(45);
        chk("rst_lost.busy", 32'(busy), 32'h0);
        commit("rst_lost");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
